fsm_seq_param: RTL and testbench
================================

Name: fsm_seq_param

Overview:
Parametrised successor to the fixed 4-state cycling FSM: a mod-NUM_STATES state sequencer.
- Commands: step up, step down, hold, load, lock and keyed unlock.
- Illegal-state recovery and command-error reporting are explicit.
- Sits between user command logic and downstream mode decoders; `out` is the current state.

Parameters:
- STATE_W, 3, width of state register and `out`; 2^STATE_W >= NUM_STATES.
- NUM_STATES, 6, number of legal states 0..NUM_STATES-1, >= 2.
- RESET_STATE, 0, state entered on reset and on illegal-state recovery; < NUM_STATES.
- UNLOCK_KEY, 5, value on `load_val` required by UNLOCK; < 2^STATE_W.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
- user_input, input, 3, command: 000 HOLD, 001 UP, 010 DOWN, 011 LOAD, 100 LOCK, 101 UNLOCK, 110/111 reserved.
- load_val, input, STATE_W, target state for LOAD; key for UNLOCK.
- out, output, STATE_W, current state, driven directly from state register.
- locked, output, 1, lock flag (registered).
- wrap, output, 1, one-cycle pulse: last step wrapped (UP from N-1 to 0, or DOWN from 0 to N-1).
- err, output, 1, one-cycle pulse: rejected command or illegal-state recovery.

Behaviour:
- Reset (rst=1 at edge): state=RESET_STATE, locked=0, wrap=0, err=0. Overrides any command on the same edge.
- Out after reset: out=RESET_STATE from the first cycle after the reset edge.
- Latency: command sampled at edge k; out/locked/wrap/err reflect it after edge k (one cycle).
- Out path: out is the registered state, no combinational path from user_input to out.
- wrap and err default to 0 every cycle unless set by the current edge's evaluation.
- Unlocked (locked=0):
  - HOLD: state unchanged.
  - UP: state+1; state N-1 goes to 0 with wrap=1.
  - DOWN: state-1; state 0 goes to N-1 with wrap=1.
  - LOAD: if load_val < NUM_STATES, state=load_val and wrap=0. Otherwise state unchanged and err=1.
  - LOCK: locked=1, state unchanged.
  - UNLOCK while already unlocked: no-op, err=0.
  - Reserved codes: state unchanged, err=1.
- Locked (locked=1):
  - Only HOLD and UNLOCK are accepted.
  - UNLOCK with load_val==UNLOCK_KEY: locked=0, state unchanged.
  - UNLOCK with wrong key: stays locked, err=1.
  - HOLD: no-op.
  - LOCK while locked: no-op.
  - UP, DOWN, LOAD, reserved: state unchanged, err=1.
- Illegal state (state >= NUM_STATES, e.g. SEU or forced value):
  - Next edge forces state=RESET_STATE and err=1, regardless of command or lock.
  - The command on that edge is discarded; locked is kept.
- Next-state logic is fully specified for every state/command pair.
  - No latches, default branch always assigned.
  - Sensitivity is complete (combinational next-state on state, user_input, load_val, locked).
- Width rules: increment/decrement computed at STATE_W bits with explicit compare against NUM_STATES-1 and 0. No reliance on natural 2^STATE_W overflow unless NUM_STATES==2^STATE_W.
- Mid-operation reset: rst asserted during any command sequence returns to reset values on that edge; no residual pulses.

Test Plan:
- Reset then 7x UP (N=6): out 0,1,2,3,4,5,0,1 across edges; wrap=1 only in the cycle out becomes 0; err=0 throughout.
- From 0, DOWN: out=5, wrap=1. Then LOAD load_val=3: out=3. Then LOAD load_val=7: out stays 3, err=1 for one cycle.
- LOCK at out=2, then UP, LOAD 4, UNLOCK key 4: out stays 2, locked=1, err pulses each cycle. Then UNLOCK key 5: locked=0, err=0. Then UP: out=3.
- Force state register to 6 (illegal) with UP applied: next edge out=0, err=1, wrap=0. Following cycle err=0.
- Reserved codes 110 and 111 while unlocked at out=4: out stays 4, err=1 per cycle.
- rst=1 on the same edge as UP while locked at out=5: out=0, locked=0, wrap=0, err=0.

Source files
------------

// File: rtl/fsm_seq_param.sv
// Parametrised mod-NUM_STATES state sequencer with up/down stepping, load,
// lock/keyed unlock, wrap and error pulses, and illegal-state recovery.
module fsm_seq_param #(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 6,
  parameter int RESET_STATE = 0,
  parameter int UNLOCK_KEY  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         user_input,
  input  logic [STATE_W-1:0] load_val,
  output logic [STATE_W-1:0] out,
  output logic               locked,
  output logic               wrap,
  output logic               err
);

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'b000,
    CMD_UP     = 3'b001,
    CMD_DOWN   = 3'b010,
    CMD_LOAD   = 3'b011,
    CMD_LOCK   = 3'b100,
    CMD_UNLOCK = 3'b101
  } cmd_e;

  localparam logic [STATE_W-1:0] LAST_ST = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] RST_ST  = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] KEY     = STATE_W'(UNLOCK_KEY);

  logic [STATE_W-1:0] state_p1, state_nxt;
  logic               locked_p1, locked_nxt;
  logic               wrap_p1, wrap_nxt;
  logic               err_p1, err_nxt;
  cmd_e               cmd;

  // Value lies inside the legal range 0..NUM_STATES-1 (compared at 32 bits so
  // NUM_STATES == 2**STATE_W is handled without overflow).
  function automatic logic in_range(input logic [STATE_W-1:0] v);
    return (32'(v) < NUM_STATES);
  endfunction

  // Step up with explicit wrap at the last legal state.
  function automatic logic [STATE_W+0:0] step_up(input logic [STATE_W-1:0] s);
    if (s == LAST_ST) return {1'b1, {STATE_W{1'b0}}};
    return {1'b0, s + STATE_W'(1)};
  endfunction

  // Step down with explicit wrap from state 0.
  function automatic logic [STATE_W+0:0] step_dn(input logic [STATE_W-1:0] s);
    if (s == '0) return {1'b1, LAST_ST};
    return {1'b0, s - STATE_W'(1)};
  endfunction

  assign cmd = cmd_e'(user_input);

  // Next-state, lock and pulse evaluation for every state/command pair.
  always_comb begin
    state_nxt  = state_p1;
    locked_nxt = locked_p1;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (!in_range(state_p1)) begin
      state_nxt = RST_ST;
      err_nxt   = 1'b1;
    end else if (locked_p1) begin
      case (cmd)
        CMD_HOLD, CMD_LOCK: ;
        CMD_UNLOCK: begin
          if (load_val == KEY) locked_nxt = 1'b0;
          else                 err_nxt    = 1'b1;
        end
        default: err_nxt = 1'b1;
      endcase
    end else begin
      case (cmd)
        CMD_HOLD, CMD_UNLOCK: ;
        CMD_UP:   {wrap_nxt, state_nxt} = step_up(state_p1);
        CMD_DOWN: {wrap_nxt, state_nxt} = step_dn(state_p1);
        CMD_LOAD: begin
          if (in_range(load_val)) state_nxt = load_val;
          else                    err_nxt   = 1'b1;
        end
        CMD_LOCK: locked_nxt = 1'b1;
        default:  err_nxt = 1'b1;
      endcase
    end
  end

  // Register stage: state, lock flag and one-cycle pulses; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= RST_ST;
      locked_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      locked_p1 <= locked_nxt;
      wrap_p1   <= wrap_nxt;
      err_p1    <= err_nxt;
    end
  end

  assign out    = state_p1;
  assign locked = locked_p1;
  assign wrap   = wrap_p1;
  assign err    = err_p1;

endmodule

// File: tb/tb_fsm_seq_param.sv
// Scoreboard bench for fsm_seq_param: driver computes expected outputs from a
// behavioural model and queues them; monitor pops and compares every cycle.
module tb_fsm_seq_param;

  localparam int SW  = 3;
  localparam int N   = 6;
  localparam int RS  = 0;
  localparam int KEY = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    user_input = 3'b000;
  logic [SW-1:0] load_val = '0;
  logic [SW-1:0] out;
  logic          locked, wrap, err;

  int checks = 0;
  int failures = 0;

  // Expected {out, locked, wrap, err}
  logic [SW+2:0] exp_q[$];

  // Reference model state
  int m_st = RS;
  bit m_lk = 1'b0;

  fsm_seq_param #(
    .STATE_W(SW), .NUM_STATES(N), .RESET_STATE(RS), .UNLOCK_KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .user_input(user_input), .load_val(load_val),
    .out(out), .locked(locked), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: optionally corrupt the state register, drive the
  // inputs, advance the model and queue the expected response.
  task automatic cyc(input bit r, input int cmd, input int lv, input bit corrupt);
    bit w, e;
    @(negedge clk);
    if (corrupt) begin
      force dut.state_p1 = 3'd6;
      #1 release dut.state_p1;
      m_st = 6;
    end
    rst = r;
    user_input = 3'(cmd);
    load_val = SW'(lv);
    w = 1'b0;
    e = 1'b0;
    if (r) begin
      m_st = RS;
      m_lk = 1'b0;
    end else if (m_st >= N) begin
      m_st = RS;
      e = 1'b1;
    end else if (m_lk) begin
      if (cmd == 5) begin
        if (lv == KEY) m_lk = 1'b0;
        else e = 1'b1;
      end else if (cmd != 0 && cmd != 4) begin
        e = 1'b1;
      end
    end else begin
      case (cmd)
        1: begin w = (m_st == N - 1); m_st = (m_st + 1) % N; end
        2: begin w = (m_st == 0); m_st = (m_st + N - 1) % N; end
        3: if (lv < N) m_st = lv; else e = 1'b1;
        4: m_lk = 1'b1;
        6, 7: e = 1'b1;
        default: ;
      endcase
    end
    exp_q.push_back({SW'(m_st), m_lk, w, e});
  endtask

  // Monitor: the sequencer presents a new output every cycle.
  initial begin
    logic [SW+2:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("out",    int'(out),    int'(x[SW+2:3]));
        check("locked", int'(locked), int'(x[2]));
        check("wrap",   int'(wrap),   int'(x[1]));
        check("err",    int'(err),    int'(x[0]));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c, lv;
    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    // 7x UP with wrap
    repeat (7) cyc(0, 1, 0, 0);
    // From 0 step DOWN, load legal and illegal values
    cyc(0, 3, 0, 0);
    cyc(0, 2, 0, 0);
    cyc(0, 3, 3, 0);
    cyc(0, 3, 7, 0);
    cyc(0, 0, 0, 0);
    // Lock at 2, rejected commands, wrong and right key, then UP
    cyc(0, 3, 2, 0);
    cyc(0, 4, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 3, 4, 0);
    cyc(0, 5, 4, 0);
    cyc(0, 5, 5, 0);
    cyc(0, 1, 0, 0);
    // Illegal state recovery with UP applied
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    // Reserved codes while unlocked at 4
    cyc(0, 3, 4, 0);
    cyc(0, 6, 0, 0);
    cyc(0, 7, 0, 0);
    // UNLOCK while unlocked is a no-op
    cyc(0, 5, 1, 0);
    // Reset on the same edge as UP while locked at 5
    cyc(0, 3, 5, 0);
    cyc(0, 4, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      c = (($urandom % 10) < 4) ? int'($urandom % 3) : int'($urandom % 8);
      lv = (($urandom % 3) == 0) ? KEY : int'($urandom % 8);
      cyc(($urandom % 40) == 0, c, lv, ($urandom % 50) == 0);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
